// File: rtl/ehgu_fifo_pkg.sv
// ehgu_fifo_pkg: shared types and width helpers for the FIFO write-side arbiter.
package ehgu_fifo_pkg;
   typedef enum logic {IDLE, LOCKED} arb_state_e;
   function automatic int lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction
   function automatic int id_w(input int nreq);
      return (nreq < 2) ? 1 : $clog2(nreq);
   endfunction
endpackage

// File: rtl/ehgu_rr_pick.sv
// ehgu_rr_pick: first set bit of req at or above start, wrapping modulo N.
module ehgu_rr_pick import ehgu_fifo_pkg::*; #(
   parameter int N  = 4,
   parameter int IW = id_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [IW-1:0] idx,
   output logic          found
);
   logic [IW-1:0] j;
   // Walk offsets high to low so the closest candidate to start wins last.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = IW'((int'(start) + k) % N);
         if (req[j]) begin
            idx   = j;
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ehgu_fifo_wr_arb.sv
// ehgu_fifo_wr_arb: round-robin, burst-locking arbiter in front of a FIFO write port,
// with credit-based backpressure from an internal occupancy counter.
module ehgu_fifo_wr_arb import ehgu_fifo_pkg::*; #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 128
) (
   input  logic                      clk0,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ-1:0]           req_last,
   input  logic [NREQ*WIDTH-1:0]     req_data,
   output logic [NREQ-1:0]           req_ready,
   input  logic                      rd_done,
   output logic                      fifo_en,
   output logic [WIDTH-1:0]          fifo_data,
   output logic [id_w(NREQ)-1:0]     grant_id,
   output logic [lvl_w(DEPTH)-1:0]   level,
   output logic                      full,
   output logic                      empty,
   output logic                      err_underflow
);
   localparam int IW = id_w(NREQ);
   localparam int LW = lvl_w(DEPTH);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   arb_state_e     state_q, state_d;
   logic [IW-1:0]  owner_q, owner_d, rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d;
   logic [LW-1:0]  level_q, level_d;
   logic           fifo_en_q, fifo_en_d, err_q, err_d;
   logic [WIDTH-1:0] fifo_data_q, fifo_data_d;
   logic [IW-1:0]  pick_idx, sel, sel_inc;
   logic           pick_found, sel_ok, space, xfer, sel_last, dec;

   ehgu_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
      .req   (req_valid),
      .start (rr_ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Backpressure uses registered level only; a same-cycle rd_done frees nothing yet.
   always_comb begin
      space     = level_q < DEPTH_L;
      sel       = (state_q == LOCKED) ? owner_q : pick_idx;
      sel_ok    = (state_q == LOCKED) || pick_found;
      req_ready = (space && sel_ok) ? (NREQ'(1) << sel) : '0;
      xfer      = |(req_valid & req_ready);
      sel_last  = req_last[sel];
      sel_inc   = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
      dec       = rd_done && (level_q != '0);
      state_d   = xfer ? (sel_last ? IDLE : LOCKED) : state_q;
      owner_d   = xfer ? sel : owner_q;
      rr_ptr_d  = (xfer && (state_q == IDLE || sel_last)) ? sel_inc : rr_ptr_q;
      level_d   = (xfer && !dec) ? level_q + LW'(1) :
                  (!xfer && dec) ? level_q - LW'(1) : level_q;
      err_d     = err_q || (rd_done && level_q == '0);
      fifo_en_d   = xfer;
      fifo_data_d = xfer ? req_data[int'(sel)*WIDTH +: WIDTH] : fifo_data_q;
      grant_id_d  = xfer ? sel : grant_id_q;
   end

   always_ff @(posedge clk0) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         level_q     <= '0;
         err_q       <= 1'b0;
         fifo_en_q   <= 1'b0;
         fifo_data_q <= '0;
         grant_id_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         level_q     <= level_d;
         err_q       <= err_d;
         fifo_en_q   <= fifo_en_d;
         fifo_data_q <= fifo_data_d;
         grant_id_q  <= grant_id_d;
      end
   end

   assign fifo_en       = fifo_en_q;
   assign fifo_data     = fifo_data_q;
   assign grant_id      = grant_id_q;
   assign level         = level_q;
   assign full          = level_q == DEPTH_L;
   assign empty         = level_q == '0;
   assign err_underflow = err_q;
endmodule

// File: tb/tb_ehgu_fifo_wr_arb.sv
// tb_ehgu_fifo_wr_arb: directed tests of arbitration, burst lock, credits and underflow (DEPTH=4).
module tb_ehgu_fifo_wr_arb;
   logic        clk0 = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0, req_last = '0, req_ready;
   logic [31:0] req_data = '0;
   logic        rd_done = 1'b0;
   logic        fifo_en, full, empty, err_underflow;
   logic [7:0]  fifo_data;
   logic [1:0]  grant_id;
   logic [2:0]  level;
   int tests = 0, fails = 0;

   ehgu_fifo_wr_arb #(.NREQ(4), .WIDTH(8), .DEPTH(4)) dut (
      .clk0(clk0), .rst(rst), .req_valid(req_valid), .req_last(req_last),
      .req_data(req_data), .req_ready(req_ready), .rd_done(rd_done),
      .fifo_en(fifo_en), .fifo_data(fifo_data), .grant_id(grant_id),
      .level(level), .full(full), .empty(empty), .err_underflow(err_underflow)
   );

   always #5 clk0 = ~clk0;

   task automatic step;
      @(posedge clk0);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; rd_done = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      tests++;
      if ({fifo_en, fifo_data, grant_id, level, full, empty, err_underflow} !== {1'b0, 8'h00, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL reset_outputs got en=%b data=%h gid=%0d lvl=%0d full=%b empty=%b err=%b exp 0/00/0/0/0/1/0",
                  fifo_en, fifo_data, grant_id, level, full, empty, err_underflow);
      end
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_rdy;
      do_reset();
      req_valid = 4'hF; req_last = 4'hF; req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int k = 0; k < 8; k++) begin
         rd_done = (k >= 1);
         exp_rdy = 4'b0001 << (k % 4);
         #1;
         tests++;
         if (req_ready !== exp_rdy) begin
            fails++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_rdy);
         end
         step();
         tests++;
         if ({fifo_en, fifo_data, grant_id, level} !== {1'b1, 8'h10 + 8'(k % 4), 2'(k % 4), 3'd1}) begin
            fails++;
            $display("FAIL rr_beat[%0d] got en=%b data=%h gid=%0d lvl=%0d exp 1/%h/%0d/1",
                     k, fifo_en, fifo_data, grant_id, level, 8'h10 + 8'(k % 4), k % 4);
         end
      end
      req_valid = '0; rd_done = 1'b1;
      step();
      rd_done = 1'b0;
      tests++;
      if ({fifo_en, level, empty} !== {1'b0, 3'd0, 1'b1}) begin
         fails++; $display("FAIL rr_idle got en=%b lvl=%0d empty=%b exp 0/0/1", fifo_en, level, empty);
      end
   endtask

   task automatic test_burst_lock;
      logic [7:0] exp_d [5] = '{8'hA0, 8'h00, 8'hA1, 8'hA2, 8'h23};
      logic [3:0] vals  [5] = '{4'b0100, 4'b1011, 4'b1111, 4'b1111, 4'b1011};
      logic [3:0] lasts [5] = '{4'b0000, 4'b1011, 4'b1011, 4'b1111, 4'b1111};
      logic [3:0] rdys  [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
      logic [1:0] gids  [5] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         req_valid = vals[k]; req_last = lasts[k];
         req_data = {8'h23, (k == 3) ? 8'hA2 : (k == 2) ? 8'hA1 : 8'hA0, 8'h21, 8'h20};
         #1;
         tests++;
         if (req_ready !== rdys[k]) begin
            fails++; $display("FAIL burst_ready[%0d] got %b exp %b", k, req_ready, rdys[k]);
         end
         step();
         tests++;
         if (k == 1 ? (fifo_en !== 1'b0) : ({fifo_en, fifo_data, grant_id} !== {1'b1, exp_d[k], gids[k]})) begin
            fails++;
            $display("FAIL burst_beat[%0d] got en=%b data=%h gid=%0d exp en=%b data=%h gid=%0d",
                     k, fifo_en, fifo_data, grant_id, k != 1, exp_d[k], gids[k]);
         end
      end
      tests++;
      if ({level, full} !== {3'd4, 1'b1}) begin
         fails++; $display("FAIL burst_level got lvl=%0d full=%b exp 4/1", level, full);
      end
      req_valid = '0;
   endtask

   task automatic test_full_backpressure;
      do_reset();
      req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_0055;
      for (int k = 0; k < 4; k++) step();
      tests++;
      if ({level, full, req_ready} !== {3'd4, 1'b1, 4'b0000}) begin
         fails++; $display("FAIL full_state got lvl=%0d full=%b rdy=%b exp 4/1/0000", level, full, req_ready);
      end
      step();
      tests++;
      if ({fifo_en, level} !== {1'b0, 3'd4}) begin
         fails++; $display("FAIL full_hold got en=%b lvl=%0d exp 0/4", fifo_en, level);
      end
      rd_done = 1'b1;
      #1;
      tests++;
      if (req_ready !== 4'b0000) begin
         fails++; $display("FAIL full_rd_ready got %b exp 0000", req_ready);
      end
      step();
      rd_done = 1'b0;
      tests++;
      if ({fifo_en, level, full} !== {1'b0, 3'd3, 1'b0}) begin
         fails++; $display("FAIL full_after_rd got en=%b lvl=%0d full=%b exp 0/3/0", fifo_en, level, full);
      end
      #1;
      tests++;
      if (req_ready !== 4'b0001) begin
         fails++; $display("FAIL full_credit_ready got %b exp 0001", req_ready);
      end
      step();
      tests++;
      if ({fifo_en, fifo_data, level, full, req_ready} !== {1'b1, 8'h55, 3'd4, 1'b1, 4'b0000}) begin
         fails++;
         $display("FAIL full_one_more got en=%b data=%h lvl=%0d full=%b rdy=%b exp 1/55/4/1/0000",
                  fifo_en, fifo_data, level, full, req_ready);
      end
      req_valid = '0;
   endtask

   task automatic test_simultaneous;
      do_reset();
      req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_0066;
      step(); step();
      rd_done = 1'b1;
      step();
      rd_done = 1'b0; req_valid = '0;
      tests++;
      if ({fifo_en, level, empty} !== {1'b1, 3'd2, 1'b0}) begin
         fails++; $display("FAIL simul_level got en=%b lvl=%0d empty=%b exp 1/2/0", fifo_en, level, empty);
      end
   endtask

   task automatic test_underflow;
      do_reset();
      rd_done = 1'b1;
      step();
      rd_done = 1'b0;
      tests++;
      if ({err_underflow, level, empty} !== {1'b1, 3'd0, 1'b1}) begin
         fails++; $display("FAIL underflow got err=%b lvl=%0d empty=%b exp 1/0/1", err_underflow, level, empty);
      end
      step();
      tests++;
      if (err_underflow !== 1'b1) begin
         fails++; $display("FAIL underflow_sticky got %b exp 1", err_underflow);
      end
   endtask

   task automatic test_reset_mid_burst;
      req_valid = 4'b0010; req_last = 4'b0000; req_data = 32'h7372_7170;
      step();
      req_valid = 4'b1111;
      #1;
      tests++;
      if (req_ready !== 4'b0010) begin
         fails++; $display("FAIL midrst_locked got %b exp 0010", req_ready);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++;
      if ({fifo_en, fifo_data, grant_id, level, full, empty, err_underflow} !== {1'b0, 8'h00, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL midrst_outputs got en=%b data=%h gid=%0d lvl=%0d full=%b empty=%b err=%b exp 0/00/0/0/0/1/0",
                  fifo_en, fifo_data, grant_id, level, full, empty, err_underflow);
      end
      req_last = 4'b1111;
      #1;
      tests++;
      if (req_ready !== 4'b0001) begin
         fails++; $display("FAIL midrst_idle_ready got %b exp 0001", req_ready);
      end
      step();
      tests++;
      if ({fifo_en, fifo_data, grant_id} !== {1'b1, 8'h70, 2'd0}) begin
         fails++; $display("FAIL midrst_first got en=%b data=%h gid=%0d exp 1/70/0", fifo_en, fifo_data, grant_id);
      end
      req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_burst_lock();
      test_full_backpressure();
      test_simultaneous();
      test_underflow();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
